// File: rtl/contador_garrafas.sv
// Bottle counter: debounces a presence sensor, counts accepted bottles per dozen,
// tallies rejects (saturating) and pulses DUZIA once per completed dozen.
module contador_garrafas #(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned DOZEN    = 12
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       SENSOR,
  input  logic       REJECT,
  input  logic       PAUSE,
  output logic [3:0] COUNT,
  output logic       DUZIA,
  output logic [3:0] REJEITADAS,
  output logic       PRESENTE
);

  localparam logic [3:0] DEB  = 4'(DEBOUNCE);
  localparam logic [3:0] LAST = 4'(DOZEN - 1);

  typedef enum logic [1:0] {IDLE, CONFIRM, PRESENT, RELEASE} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] count_q, count_d;
  logic [3:0] rej_q, rej_d;
  logic       duzia_q, duzia_d;
  logic       evento;

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      count_q <= 4'd0;
      rej_q   <= 4'd0;
      duzia_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      rej_q   <= rej_d;
      duzia_q <= duzia_d;
    end
  end

  // EVENT fires in the same cycle the FSM commits to PRESENT, so the counters
  // sample REJECT/PAUSE in that cycle and update on the edge that enters PRESENT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evento  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (SENSOR) begin
          if (DEB == 4'd1) begin
            state_d = PRESENT;
            evento  = 1'b1;
          end else begin
            state_d = CONFIRM;
            cnt_d   = 4'd1;
          end
        end
      end
      CONFIRM: begin
        if (!SENSOR) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q + 4'd1 == DEB) begin
          state_d = PRESENT;
          cnt_d   = 4'd0;
          evento  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      PRESENT: begin
        cnt_d = 4'd0;
        if (!SENSOR) begin
          if (DEB == 4'd1) begin
            state_d = IDLE;
          end else begin
            state_d = RELEASE;
            cnt_d   = 4'd1;
          end
        end
      end
      RELEASE: begin
        if (SENSOR) begin
          state_d = PRESENT;
          cnt_d   = 4'd0;
        end else if (cnt_q + 4'd1 == DEB) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    rej_d   = rej_q;
    duzia_d = 1'b0;
    if (evento && !PAUSE) begin
      if (REJECT) begin
        if (rej_q != 4'd15) rej_d = rej_q + 4'd1;
      end else if (count_q == LAST) begin
        count_d = 4'd0;
        duzia_d = 1'b1;
      end else begin
        count_d = count_q + 4'd1;
      end
    end
  end

  assign COUNT      = count_q;
  assign DUZIA      = duzia_q;
  assign REJEITADAS = rej_q;
  assign PRESENTE   = (state_q == PRESENT) || (state_q == RELEASE);

endmodule

// File: tb/tb_contador_garrafas.sv
// Bench for contador_garrafas: two instances (defaults, and DEBOUNCE=1/DOZEN=2)
// checked every cycle against a run-length behavioural model plus literal checks.
module tb_contador_garrafas;

  logic       clock = 1'b0;
  logic       reset;
  logic       sensor;
  logic       reject;
  logic       pause;

  logic [3:0] count1, rej1, count2, rej2;
  logic       duzia1, pres1, duzia2, pres2;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;
  int duzPulses = 0;

  int mDeb[2] = '{3, 1};
  int mDoz[2] = '{12, 2};
  int mLvl[2], mRun[2], mCount[2], mRej[2], mDuz[2];

  always #5 clock = ~clock;

  contador_garrafas #(.DEBOUNCE(3), .DOZEN(12)) dutA (
    .CLOCK(clock), .RESET(reset), .SENSOR(sensor), .REJECT(reject), .PAUSE(pause),
    .COUNT(count1), .DUZIA(duzia1), .REJEITADAS(rej1), .PRESENTE(pres1)
  );

  contador_garrafas #(.DEBOUNCE(1), .DOZEN(2)) dutB (
    .CLOCK(clock), .RESET(reset), .SENSOR(sensor), .REJECT(reject), .PAUSE(pause),
    .COUNT(count2), .DUZIA(duzia2), .REJEITADAS(rej2), .PRESENTE(pres2)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the accepted level flips once the sensor has disagreed with it for
  // DEBOUNCE consecutive samples; a 0->1 flip is one bottle.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        mLvl[k] = 0; mRun[k] = 0; mCount[k] = 0; mRej[k] = 0; mDuz[k] = 0;
      end else begin
        mDuz[k] = 0;
        if (int'(sensor) != mLvl[k]) mRun[k]++;
        else mRun[k] = 0;
        if (mRun[k] == mDeb[k]) begin
          mLvl[k] = int'(sensor);
          mRun[k] = 0;
          if (mLvl[k] == 1 && !pause) begin
            if (reject) mRej[k] = (mRej[k] < 15) ? mRej[k] + 1 : 15;
            else if (mCount[k] + 1 == mDoz[k]) begin
              mCount[k] = 0;
              mDuz[k] = 1;
            end else mCount[k]++;
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("A.count", int'(count1), mCount[0]);
      checkOutput("A.duzia", int'(duzia1), mDuz[0]);
      checkOutput("A.rej",   int'(rej1),   mRej[0]);
      checkOutput("A.pres",  int'(pres1),  mLvl[0]);
      checkOutput("B.count", int'(count2), mCount[1]);
      checkOutput("B.duzia", int'(duzia2), mDuz[1]);
      checkOutput("B.rej",   int'(rej2),   mRej[1]);
      checkOutput("B.pres",  int'(pres2),  mLvl[1]);
      if (duzia1) duzPulses++;
    end
  end

  task automatic applyStimulus(input logic s);
    sensor = s;
    @(negedge clock);
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    reset = 1'b1;
  endtask

  task automatic bottle();
    repeat (5) applyStimulus(1'b1);
    repeat (5) applyStimulus(1'b0);
  endtask

  initial begin
    logic [7:0] bouncePat;
    reset = 1'b0; sensor = 1'b0; reject = 1'b0; pause = 1'b0;
    @(negedge clock);
    checkEn = 1'b1;
    checkOutput("rst.count", int'(count1), 0);
    checkOutput("rst.rej",   int'(rej1),   0);
    checkOutput("rst.pres",  int'(pres1),  0);
    checkOutput("rst.duzia", int'(duzia1), 0);
    applyStimulus(1'b0);
    reset = 1'b1;

    // Single clean bottle: PRESENTE rises on the third high sample.
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("single.pres_early", int'(pres1), 0);
    applyStimulus(1'b1);
    checkOutput("single.pres_rise", int'(pres1), 1);
    checkOutput("single.count", int'(count1), 1);
    repeat (2) applyStimulus(1'b1);
    repeat (5) applyStimulus(1'b0);
    checkOutput("single.count_after", int'(count1), 1);
    checkOutput("single.pres_fall", int'(pres1), 0);

    // Bounce on rise, then a glitch while releasing.
    bouncePat = 8'b1110_1101;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(bouncePat[i]);
      if (i == 6) checkOutput("bounce.before", int'(count1), 1);
    end
    checkOutput("bounce.event", int'(count1), 2);
    repeat (3) applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    repeat (5) applyStimulus(1'b0);
    checkOutput("bounce.glitch", int'(count1), 2);

    // Dozen wrap.
    doReset();
    duzPulses = 0;
    repeat (11) bottle();
    checkOutput("wrap.eleven", int'(count1), 11);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("wrap.pre_duzia", int'(duzia1), 0);
    applyStimulus(1'b1);
    checkOutput("wrap.count0", int'(count1), 0);
    checkOutput("wrap.duzia", int'(duzia1), 1);
    applyStimulus(1'b1);
    checkOutput("wrap.duzia_end", int'(duzia1), 0);
    repeat (5) applyStimulus(1'b0);
    checkOutput("wrap.pulses", duzPulses, 1);

    // Rejects, paused bottles, then saturation.
    doReset();
    reject = 1'b1;
    repeat (3) bottle();
    pause = 1'b1;
    repeat (2) bottle();
    checkOutput("rej.three", int'(rej1), 3);
    checkOutput("rej.count", int'(count1), 0);
    pause = 1'b0;
    repeat (20) bottle();
    checkOutput("rej.sat", int'(rej1), 15);
    reject = 1'b0;

    // Reset while confirming a bottle with the sensor held high.
    doReset();
    repeat (7) bottle();
    checkOutput("rstmid.seven", int'(count1), 7);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    reset = 1'b0;
    applyStimulus(1'b1);
    checkOutput("rstmid.count", int'(count1), 0);
    checkOutput("rstmid.pres",  int'(pres1),  0);
    checkOutput("rstmid.rej",   int'(rej1),   0);
    checkOutput("rstmid.duzia", int'(duzia1), 0);
    reset = 1'b1;
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("rstmid.wait", int'(count1), 0);
    applyStimulus(1'b1);
    checkOutput("rstmid.recount", int'(count1), 1);
    repeat (5) applyStimulus(1'b0);

    // DEBOUNCE=1, DOZEN=2 instance.
    doReset();
    checkOutput("d1.count0", int'(count2), 0);
    applyStimulus(1'b1);
    checkOutput("d1.count1", int'(count2), 1);
    checkOutput("d1.pres", int'(pres2), 1);
    applyStimulus(1'b0);
    checkOutput("d1.pres_fall", int'(pres2), 0);
    applyStimulus(1'b1);
    checkOutput("d1.wrap", int'(count2), 0);
    checkOutput("d1.duzia", int'(duzia2), 1);
    applyStimulus(1'b0);
    checkOutput("d1.duzia_end", int'(duzia2), 0);

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/contador_garrafas.md
CONTADOR_GARRAFAS -- requirements
Module: contador_garrafas

Interface
REQ-001 The module SHALL have parameter DEBOUNCE, default 3, which sets the number of consecutive stable samples needed to accept a SENSOR level (legal range 1..15).
REQ-002 The module SHALL have parameter DOZEN, default 12, which sets the accepted bottles per dozen (legal range 2..15).
REQ-003 The module SHALL have port CLOCK  input  1  as its single clock; all state SHALL update on the rising edge.
REQ-004 The module SHALL have port RESET  input  1  as a synchronous, active-low reset.
REQ-005 The module SHALL have port SENSOR  input  1  carrying the raw, possibly bouncing, bottle-presence sensor (1 = bottle present).
REQ-006 The module SHALL have port REJECT  input  1  carrying the quality-check flag for the bottle currently at the sensor.
REQ-007 The module SHALL have port PAUSE  input  1  which halts counting of new bottles.
REQ-008 The module SHALL have port COUNT  output  4  giving the accepted bottles in the current dozen (0..DOZEN-1).
REQ-009 The module SHALL have port DUZIA  output  1  carrying a one-cycle pulse per completed dozen; it SHALL be the ENABLE source of the downstream dozen counter.
REQ-010 The module SHALL have port REJEITADAS  output  4  giving the rejected-bottle count, saturating at 15.
REQ-011 The module SHALL have port PRESENTE  output  1  giving the debounced bottle-present level.

Function
REQ-012 The debounce FSM SHALL have the states IDLE, CONFIRM, PRESENT and RELEASE, plus a 4-bit stability counter CNT.
REQ-013 In IDLE, SENSOR=1 SHALL cause a move to CONFIRM with CNT=1; SENSOR=0 SHALL keep the FSM in IDLE.
REQ-014 In CONFIRM, SENSOR=1 SHALL increment CNT; when CNT reaches DEBOUNCE, the FSM SHALL move to PRESENT and raise a one-cycle internal EVENT; SENSOR=0 SHALL return the FSM to IDLE with CNT=0.
REQ-015 With DEBOUNCE=1, EVENT SHALL be raised on the first cycle SENSOR=1 is sampled in IDLE, and the FSM SHALL go directly to PRESENT.
REQ-016 In PRESENT, SENSOR=0 SHALL cause a move to RELEASE with CNT=1; in RELEASE, SENSOR=0 SHALL increment CNT, and reaching DEBOUNCE SHALL cause a move to IDLE; SENSOR=1 in RELEASE SHALL return the FSM to PRESENT with no new EVENT.
REQ-017 PRESENTE SHALL be 1 exactly while the FSM is in PRESENT or RELEASE.
REQ-018 At most one EVENT SHALL be generated per bottle, regardless of sensor bounce.
REQ-019 REJECT and PAUSE SHALL be sampled only in the EVENT cycle.
REQ-020 An EVENT with PAUSE=1 SHALL be discarded: no change to COUNT, REJEITADAS or DUZIA; PAUSE SHALL take priority over REJECT.
REQ-021 An EVENT with PAUSE=0 and REJECT=1 SHALL increment REJEITADAS, saturating at 15, and SHALL leave COUNT unchanged.
REQ-022 An EVENT with PAUSE=0 and REJECT=0 SHALL increment COUNT on the next edge; if COUNT = DOZEN-1, COUNT SHALL instead become 0 and DUZIA SHALL be 1 for exactly the following cycle.
REQ-023 DUZIA SHALL be registered: it is 0 except for the single cycle after a dozen completes; no two DUZIA pulses SHALL be closer than 2*DEBOUNCE cycles apart.
REQ-024 COUNT SHALL never exceed DOZEN-1; the wrap from DOZEN-1 to 0 SHALL occur only on an accepted EVENT.
REQ-025 PAUSE SHALL NOT freeze the FSM; debouncing SHALL continue while paused.

Reset
REQ-026 With RESET=0 at a rising edge, the next state SHALL be: FSM=IDLE, CNT=0, COUNT=0, REJEITADAS=0, DUZIA=0, PRESENTE=0.
REQ-027 Reset SHALL override all other inputs in the same edge, including mid-debounce and during a DUZIA cycle; a pending EVENT SHALL be lost.
REQ-028 After RESET returns to 1, a SENSOR already high SHALL be treated as a new bottle, debounced from IDLE.

Verification
REQ-029 Single bottle (defaults): SENSOR high 5 cycles, then low 5 cycles -> PRESENTE rises 3 cycles after SENSOR rises; COUNT goes 0->1; DUZIA stays 0.
REQ-030 Bounce: SENSOR pattern 1,0,1,1,0,1,1,1 then held high -> exactly one EVENT, on the third consecutive 1; COUNT=1; a 1,0,1 glitch during RELEASE -> no extra count.
REQ-031 Dozen wrap: 12 clean accepted bottles -> COUNT steps 1..11, then 0; DUZIA is high for exactly one cycle after the 12th bottle's EVENT edge.
REQ-032 Reject/pause: 3 bottles with REJECT=1, 2 bottles with PAUSE=1 (REJECT=1) -> REJEITADAS=3, COUNT=0; 20 rejected bottles -> REJEITADAS=15.
REQ-033 Reset mid-operation: COUNT=7, RESET=0 asserted for 1 cycle in CONFIRM with SENSOR held high -> all outputs 0; the bottle is re-debounced and COUNT becomes 1 DEBOUNCE cycles after release.
REQ-034 DEBOUNCE=1, DOZEN=2: two bottles -> EVENT on the first high sample of each; DUZIA pulses once; COUNT sequence is 0,1,0.
